exe_mem_skid_reg: RTL and testbench
===================================

EXE_MEM_SKID_REG -- requirements
Module: exe_mem_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of alu_res and val_rm.
REQ-002 SHALL have parameter DEST_W, default 4, width of dest.
REQ-003 SHALL have parameter CNT_W, default 16, width of stall_cnt.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-005 Ports (name direction width meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline flush (branch taken)
- in_valid  in  1  EXE stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- WB_en_in, MEM_r_en_in, MEM_w_en_in  in  1 each  control bits from EXE
- dest_in  in  DEST_W  destination register
- alu_res_in, val_rm_in  in  DATA_W each  ALU result, store data
- out_valid  out  1  MEM stage is offered an instruction
- out_ready  in  1  MEM stage accepts (low = memory stall)
- WB_en_out, MEM_r_en_out, MEM_w_en_out  out  1 each  control bits, qualified by out_valid
- dest_out  out  DEST_W; alu_res_out, val_rm_out  out  DATA_W each  payload of head entry
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Function
REQ-006 SHALL hold two entries, MAIN (head, drives outputs) and SKID. Each entry carries the 3 control bits, dest, alu_res, val_rm and a valid bit.
REQ-007 SHALL have states EMPTY (occupancy 0), ONE (MAIN valid), TWO (MAIN and SKID valid).
REQ-008 in_ready SHALL be a registered signal, equal to 1 in EMPTY and ONE and 0 in TWO; it SHALL NOT depend combinationally on out_ready.
REQ-009 accept = in_valid & in_ready; drain = out_valid & out_ready; out_valid = MAIN valid.
REQ-010 EMPTY: accept -> input loaded into MAIN, next state ONE; no accept -> stay.
REQ-011 ONE:
- accept & drain -> MAIN <= input, stay ONE.
- accept & !drain -> SKID <= input, go to TWO.
- !accept & drain -> go to EMPTY.
- otherwise hold.
REQ-012 TWO: drain -> MAIN <= SKID, SKID invalid, go to ONE; !drain -> hold all contents.
REQ-013 Ordering SHALL be strict FIFO. Latency from accept to out_valid is 1 cycle when the block is EMPTY.
REQ-014 WB_en_out, MEM_r_en_out and MEM_w_en_out SHALL equal the MAIN bits ANDed with out_valid. The data outputs show MAIN contents regardless of valid.
REQ-015 flush SHALL clear both valid bits and go to EMPTY on the next edge. Any accept in the same cycle is discarded. A drain in the same cycle still completes. in_ready is 1 the cycle after a flush.
REQ-016 Priority: rst > flush > normal operation.
REQ-017 stall_cnt SHALL increment when out_valid & !out_ready, saturate at 2^CNT_W-1, and clear only on rst (flush does not clear it).
REQ-018 Payload registers of invalid entries need not change. When valid=0, observable state is limited to the qualified control outputs.

Reset
REQ-019 On rst the block SHALL enter EMPTY, with out_valid=0, all three control outputs=0, dest_out=0, alu_res_out=0, val_rm_out=0, occupancy=0, stall_cnt=0, and in_ready=1 from the first cycle after rst deasserts.
REQ-020 rst asserted mid-operation in TWO SHALL discard both entries with no drain reported.
REQ-021 rst SHALL be sampled only at the rising edge of clk; rst pulses between edges have no effect.

Verification
REQ-022 Streaming: out_ready=1, push A(alu_res=0x11,dest=1) and B(0x22,dest=2) on consecutive cycles -> A on outputs 1 cycle after its push, B the next cycle, occupancy never exceeds 1.
REQ-023 Backpressure: out_ready=0, push A, B, C -> A and B accepted, in_ready=0 after B, C held off, occupancy=2, out shows A. Then out_ready=1 -> A, B, C delivered in order.
REQ-024 Flush: state TWO, flush=1 with in_valid=1 (D) -> next cycle out_valid=0, occupancy=0, WB_en_out=0, D never appears on the outputs.
REQ-025 Stall counter: CNT_W=2, hold out_valid=1 with out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3,3. A flush leaves it at 3; rst sets it to 0.
REQ-026 Reset mid-op: state TWO, rst=1 for one cycle -> all outputs 0, occupancy=0, in_ready=1 on the following cycle, and the next push appears after 1 cycle.
REQ-027 Random test: random in_valid/out_ready/flush checked against a FIFO scoreboard -> no loss, no duplication, and no reordering of non-flushed entries.

Source files
------------

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with a two-entry skid buffer.
// in_ready is registered so upstream timing never sees out_ready combinationally.
module exe_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_en_in,
    input  logic              MEM_r_en_in,
    input  logic              MEM_w_en_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_en_out,
    output logic              MEM_r_en_out,
    output logic              MEM_w_en_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

    typedef struct packed {
        logic              wb;
        logic              mr;
        logic              mw;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rm;
    } entry_t;

    state_e             state_q, state_d;
    entry_t             main_q, main_d, skid_q, skid_d, in_ent;
    logic               in_ready_q;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               main_valid, accept, drain;

    assign in_ent     = {WB_en_in, MEM_r_en_in, MEM_w_en_in, dest_in, alu_res_in, val_rm_in};
    assign main_valid = (state_q != S_EMPTY);
    assign accept     = in_valid & in_ready_q;
    assign drain      = main_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_d  = in_ent;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    main_d = in_ent;
                end else if (accept) begin
                    skid_d  = in_ent;
                    state_d = S_TWO;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (drain) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush drops both entries and any same-cycle accept; payload simply holds.
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != S_TWO);
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            S_ONE:   occupancy = 2'd1;
            S_TWO:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = main_valid;
    assign WB_en_out    = main_q.wb & main_valid;
    assign MEM_r_en_out = main_q.mr & main_valid;
    assign MEM_w_en_out = main_q.mw & main_valid;
    assign dest_out     = main_q.dest;
    assign alu_res_out  = main_q.alu;
    assign val_rm_out   = main_q.rm;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Directed and randomized checks of exe_mem_skid_reg against hand-computed values and a FIFO model.
module tb_exe_mem_skid_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        WB_en_in, MEM_r_en_in, MEM_w_en_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_res_in, val_rm_in;

    logic        in_ready, out_valid, WB_en_out, MEM_r_en_out, MEM_w_en_out;
    logic [3:0]  dest_out;
    logic [31:0] alu_res_out, val_rm_out;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        c2_in_ready, c2_out_valid, c2_wb, c2_mr, c2_mw;
    logic [3:0]  c2_dest;
    logic [31:0] c2_alu, c2_rm;
    logic [1:0]  c2_occ;
    logic [1:0]  c2_stall;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    exe_mem_skid_reg #(.DATA_W(32), .DEST_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .WB_en_in(WB_en_in), .MEM_r_en_in(MEM_r_en_in), .MEM_w_en_in(MEM_w_en_in),
        .dest_in(dest_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .WB_en_out(WB_en_out), .MEM_r_en_out(MEM_r_en_out), .MEM_w_en_out(MEM_w_en_out),
        .dest_out(dest_out), .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    exe_mem_skid_reg #(.DATA_W(32), .DEST_W(4), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c2_in_ready),
        .WB_en_in(WB_en_in), .MEM_r_en_in(MEM_r_en_in), .MEM_w_en_in(MEM_w_en_in),
        .dest_in(dest_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
        .out_valid(c2_out_valid), .out_ready(out_ready),
        .WB_en_out(c2_wb), .MEM_r_en_out(c2_mr), .MEM_w_en_out(c2_mw),
        .dest_out(c2_dest), .alu_res_out(c2_alu), .val_rm_out(c2_rm),
        .occupancy(c2_occ), .stall_cnt(c2_stall)
    );

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic        mw;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] rm;
    } ent_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [3:0] d, input logic wb);
        in_valid    = v;
        alu_res_in  = alu;
        dest_in     = d;
        val_rm_in   = ~alu;
        WB_en_in    = wb;
        MEM_r_en_in = 1'b0;
        MEM_w_en_in = wb;
    endtask

    ent_t q[$];
    ent_t e;
    logic model_acc, model_drn;
    int unsigned tag_ctr;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb", WB_en_out, 0);
        chk("rst_dest", dest_out, 0);
        chk("rst_alu", alu_res_out, 0);
        chk("rst_rm", val_rm_out, 0);
        chk("rst_stall", stall_cnt, 0);

        // streaming
        out_ready = 1'b1;
        drive(1'b1, 32'h11, 4'd1, 1'b1);
        step();
        chk("str_A_valid", out_valid, 1);
        chk("str_A_alu", alu_res_out, 32'h11);
        chk("str_A_dest", dest_out, 1);
        chk("str_A_wb", WB_en_out, 1);
        chk("str_A_memw", MEM_w_en_out, 1);
        chk("str_A_occ", occupancy, 1);
        drive(1'b1, 32'h22, 4'd2, 1'b1);
        step();
        chk("str_B_alu", alu_res_out, 32'h22);
        chk("str_B_dest", dest_out, 2);
        chk("str_B_occ", occupancy, 1);
        drive(1'b0, 32'h0, 4'd0, 1'b1);
        step();
        chk("str_end_valid", out_valid, 0);
        chk("str_end_occ", occupancy, 0);
        chk("str_end_wb", WB_en_out, 0);

        // backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'hA1, 4'd3, 1'b1);
        step();
        chk("bp_A_inrdy", in_ready, 1);
        drive(1'b1, 32'hB2, 4'd4, 1'b0);
        step();
        chk("bp_B_inrdy", in_ready, 0);
        chk("bp_B_occ", occupancy, 2);
        chk("bp_B_alu", alu_res_out, 32'hA1);
        drive(1'b1, 32'hC3, 4'd5, 1'b1);
        step();
        chk("bp_C_held_occ", occupancy, 2);
        chk("bp_C_held_alu", alu_res_out, 32'hA1);
        chk("bp_C_held_inrdy", in_ready, 0);
        chk("bp_stall", stall_cnt, 2);
        out_ready = 1'b1;
        step();
        chk("bp_out_B", alu_res_out, 32'hB2);
        chk("bp_out_B_wb", WB_en_out, 0);
        chk("bp_out_B_occ", occupancy, 1);
        chk("bp_out_B_inrdy", in_ready, 1);
        step();
        chk("bp_out_C", alu_res_out, 32'hC3);
        chk("bp_out_C_dest", dest_out, 5);
        drive(1'b0, 32'h0, 4'd0, 1'b0);
        step();
        chk("bp_end_valid", out_valid, 0);

        // flush from TWO with a concurrent push
        out_ready = 1'b0;
        drive(1'b1, 32'hE1, 4'd6, 1'b1);
        step();
        drive(1'b1, 32'hF2, 4'd7, 1'b1);
        step();
        chk("fl_pre_occ", occupancy, 2);
        drive(1'b1, 32'hD4, 4'd8, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'd0, 1'b0);
        chk("fl_valid", out_valid, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_wb", WB_en_out, 0);
        chk("fl_inrdy", in_ready, 1);
        chk("fl_stall_kept", stall_cnt, 4);
        step();
        chk("fl_no_D", out_valid, 0);

        // saturating stall counter
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 4'd9, 1'b1);
        step();
        drive(1'b0, 32'h0, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("sat_c2", c2_stall, (i < 3) ? i + 1 : 3);
            chk("sat_c16", stall_cnt, i + 1);
        end
        flush = 1'b1; step(); flush = 1'b0;
        chk("sat_flush_c2", c2_stall, 3);
        rst = 1'b1; step(); rst = 1'b0;
        chk("sat_rst_c2", c2_stall, 0);
        chk("sat_rst_c16", stall_cnt, 0);

        // reset mid-operation in TWO
        drive(1'b1, 32'h71, 4'd1, 1'b1);
        step();
        drive(1'b1, 32'h72, 4'd2, 1'b1);
        step();
        chk("rmo_pre_occ", occupancy, 2);
        drive(1'b0, 32'h0, 4'd0, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rmo_valid", out_valid, 0);
        chk("rmo_occ", occupancy, 0);
        chk("rmo_alu", alu_res_out, 0);
        chk("rmo_dest", dest_out, 0);
        chk("rmo_wb", WB_en_out, 0);
        chk("rmo_inrdy", in_ready, 1);
        drive(1'b1, 32'h3C, 4'hC, 1'b1);
        step();
        drive(1'b0, 32'h0, 4'd0, 1'b0);
        chk("rmo_push_valid", out_valid, 1);
        chk("rmo_push_alu", alu_res_out, 32'h3C);

        // reset pulse between edges is ignored
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        step();
        chk("glitch_occ", occupancy, 1);
        chk("glitch_alu", alu_res_out, 32'h3C);
        out_ready = 1'b1;
        step();
        chk("glitch_drain", out_valid, 0);

        // random traffic vs FIFO model
        tag_ctr = 32'h100;
        for (int n = 0; n < 600; n++) begin
            e.wb   = 1'($urandom_range(0, 1));
            e.mr   = 1'($urandom_range(0, 1));
            e.mw   = 1'($urandom_range(0, 1));
            e.alu  = tag_ctr;
            e.dest = tag_ctr[3:0];
            e.rm   = ~tag_ctr;
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            WB_en_in    = e.wb;
            MEM_r_en_in = e.mr;
            MEM_w_en_in = e.mw;
            dest_in     = e.dest;
            alu_res_in  = e.alu;
            val_rm_in   = e.rm;
            model_acc = in_valid && (q.size() < 2);
            model_drn = (q.size() > 0) && out_ready;
            step();
            if (flush) begin
                q.delete();
            end else begin
                if (model_drn) void'(q.pop_front());
                if (model_acc) begin
                    q.push_back(e);
                    tag_ctr++;
                end
            end
            chk("rnd_occ", occupancy, q.size());
            chk("rnd_valid", out_valid, q.size() > 0);
            chk("rnd_inrdy", in_ready, q.size() < 2);
            if (q.size() > 0) begin
                chk("rnd_alu", alu_res_out, q[0].alu);
                chk("rnd_rm", val_rm_out, q[0].rm);
                chk("rnd_dest", dest_out, q[0].dest);
                chk("rnd_ctl", {WB_en_out, MEM_r_en_out, MEM_w_en_out}, {q[0].wb, q[0].mr, q[0].mw});
            end else begin
                chk("rnd_ctl_idle", {WB_en_out, MEM_r_en_out, MEM_w_en_out}, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
